// File: rtl/sha256_pkg.sv
// SHA-256 constants, bit functions and shared types for the block engine.
package sha256_pkg;

    typedef logic [7:0][31:0] word8_t;
    typedef logic [15:0][31:0] block_t;

    typedef enum logic [2:0] {StIdle, StPrep, StRound, StFinal, StOut} state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Concatenation lists H7 first so that IV[0] is H0.
    localparam word8_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; state index 0..7 holds a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  word8_t      st_i,
    input  logic [31:0] kw_i,
    output word8_t      st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + kw_i;
        t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
        st_o[0] = t1 + t2;
        st_o[1] = st_i[0];
        st_o[2] = st_i[1];
        st_o[3] = st_i[2];
        st_o[4] = st_i[3] + t1;
        st_o[5] = st_i[4];
        st_o[6] = st_i[5];
        st_o[7] = st_i[6];
    end

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 block compressor with handshakes, 1/2/4 rounds per clock and an internal
// chaining register for multi-block and midstate-resumed hashing.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned TAG_W            = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  block_t           block,
    input  logic [1:0]       hash_sel,
    input  word8_t           init_hash,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output word8_t           digest,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned R = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LastCnt = 6'(64 - R);

    if (R != 1 && R != 2 && R != 4) begin : g_bad_param
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_e           state_q, state_d;
    word8_t           base_q, base_d;
    word8_t           work_q, work_d;
    block_t           win_q, win_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    word8_t           digest_q, digest_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    word8_t           chain_q, chain_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0] ext [16+R];
    word8_t      rs [R+1];
    word8_t      fin;

    // ext[16..16+R-1] are the schedule words that enter the window this cycle.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) ext[i] = win_q[i];
        for (int unsigned j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
    end

    assign rs[0] = work_q;

    for (genvar j = 0; j < R; j++) begin : g_round
        logic [31:0] kw;
        assign kw = K[cnt_q + 6'(j)] + win_q[j];
        sha256_round u_round (
            .st_i (rs[j]),
            .kw_i (kw),
            .st_o (rs[j+1])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) fin[i] = base_q[i] + work_q[i];
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        work_d      = work_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        digest_d    = digest_q;
        out_tag_d   = out_tag_q;
        chain_d     = chain_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    win_d = block;
                    tag_d = in_tag;
                    case (hash_sel)
                        2'd1:    base_d = init_hash;
                        2'd2:    base_d = chain_q;
                        default: base_d = IV;
                    endcase
                    state_d = StPrep;
                end
            end
            StPrep: begin
                work_d  = base_q;
                cnt_d   = '0;
                state_d = StRound;
            end
            StRound: begin
                work_d = rs[R];
                for (int unsigned i = 0; i < 16; i++) win_d[i] = ext[i+R];
                cnt_d = cnt_q + 6'(R);
                if (cnt_q == LastCnt) state_d = StFinal;
            end
            StFinal: begin
                digest_d    = fin;
                chain_d     = fin;
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            work_q      <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            digest_q    <= '0;
            out_tag_q   <= '0;
            chain_q     <= IV;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            work_q      <= work_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            digest_q    <= digest_d;
            out_tag_q   <= out_tag_d;
            chain_q     <= chain_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign digest    = digest_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed and model-based bench for sha256_block_engine at 1, 2 and 4 rounds per cycle.
module tb_sha256_block_engine;

    typedef logic [7:0][31:0]  hash_t;
    typedef logic [15:0][31:0] blk_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    blk_t       block = '0;
    logic [1:0] hash_sel = '0;
    hash_t      init_hash = '0;
    logic [7:0] in_tag = '0;

    logic in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2;
    logic in_ready4, out_valid4, busy4;
    hash_t digest1, digest2, digest4;
    logic [7:0] out_tag1, out_tag2, out_tag4;

    int errors = 0;
    int checks = 0;

    hash_t iv_h, abc_h, two_h, mid_digest;
    blk_t  abc_b, two_b1, two_b2;

    always #5 clk = ~clk;

    sha256_block_engine #(.ROUNDS_PER_CYCLE(1), .TAG_W(8)) u_dut_r1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .block(block), .hash_sel(hash_sel), .init_hash(init_hash), .in_tag(in_tag),
        .out_valid(out_valid1), .out_ready(out_ready), .digest(digest1),
        .out_tag(out_tag1), .busy(busy1)
    );

    sha256_block_engine #(.ROUNDS_PER_CYCLE(2), .TAG_W(8)) u_dut_r2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .block(block), .hash_sel(hash_sel), .init_hash(init_hash), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .digest(digest2),
        .out_tag(out_tag2), .busy(busy2)
    );

    sha256_block_engine #(.ROUNDS_PER_CYCLE(4), .TAG_W(8)) u_dut_r4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .block(block), .hash_sel(hash_sel), .init_hash(init_hash), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready), .digest(digest4),
        .out_tag(out_tag4), .busy(busy4)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic hash_t mk8(input logic [31:0] h0, input logic [31:0] h1,
                                  input logic [31:0] h2, input logic [31:0] h3,
                                  input logic [31:0] h4, input logic [31:0] h5,
                                  input logic [31:0] h6, input logic [31:0] h7);
        hash_t r;
        r[0] = h0; r[1] = h1; r[2] = h2; r[3] = h3;
        r[4] = h4; r[5] = h5; r[6] = h6; r[7] = h7;
        return r;
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression using a fully expanded 64-word schedule.
    function automatic hash_t compress(input hash_t h, input blk_t b);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        hash_t r;
        for (int t = 0; t < 16; t++) w[t] = b[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
        return r;
    endfunction

    function automatic logic ov(input int r);
        case (r)
            1:       return out_valid1;
            2:       return out_valid2;
            default: return out_valid4;
        endcase
    endfunction

    function automatic hash_t dg(input int r);
        case (r)
            1:       return digest1;
            2:       return digest2;
            default: return digest4;
        endcase
    endfunction

    function automatic logic [7:0] tg(input int r);
        case (r)
            1:       return out_tag1;
            2:       return out_tag2;
            default: return out_tag4;
        endcase
    endfunction

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            if (in_ready1 && in_ready2 && in_ready4) break;
            @(posedge clk); #1;
        end
        checks++;
        if (!(in_ready1 && in_ready2 && in_ready4)) begin
            errors++;
            $display("FAIL idle_timeout: in_ready r1/r2/r4=%b%b%b want 111",
                     in_ready1, in_ready2, in_ready4);
        end
    endtask

    // Offers one block, scrambles the inputs after the accept edge, then measures edges
    // until the selected instance raises out_valid (lat = -1 on timeout).
    task automatic run_block(input logic [1:0] sel, input hash_t ih, input blk_t b,
                             input logic [7:0] tag, input int r,
                             output int lat, output hash_t dig, output logic [7:0] otag);
        wait_idle();
        hash_sel = sel; init_hash = ih; block = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        block     = {16{$urandom()}};
        init_hash = {8{$urandom()}};
        hash_sel  = 2'($urandom());
        in_tag    = 8'($urandom());
        lat = -1; dig = '0; otag = '0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (ov(r)) begin
                lat = n; dig = dg(r); otag = tg(r);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({in_ready1, in_ready2, in_ready4} !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready: got %b want 111",
                               {in_ready1, in_ready2, in_ready4});
        end
        checks++;
        if ({out_valid1, out_valid2, out_valid4, busy1, busy2, busy4} !== 6'b0) begin
            errors++; $display("FAIL reset_valid_busy: got %b want 000000",
                               {out_valid1, out_valid2, out_valid4, busy1, busy2, busy4});
        end
        checks++;
        if (digest1 !== '0 || digest4 !== '0) begin
            errors++; $display("FAIL reset_digest: got %h / %h want 0", digest1, digest4);
        end
        checks++;
        if (out_tag1 !== 8'h00 || out_tag2 !== 8'h00) begin
            errors++; $display("FAIL reset_tag: got %h / %h want 00", out_tag1, out_tag2);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc_r1();
        int lat; hash_t dig; logic [7:0] t;
        run_block(2'd0, '0, abc_b, 8'h5a, 1, lat, dig, t);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL abc_latency: got %0d want 66", lat); end
        checks++;
        if (dig !== abc_h) begin errors++; $display("FAIL abc_digest: got %h want %h", dig, abc_h); end
        checks++;
        if (t !== 8'h5a) begin errors++; $display("FAIL abc_tag: got %h want 5a", t); end
        @(posedge clk); #1;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL abc_release: out_valid=%b in_ready=%b want 0 1",
                               out_valid1, in_ready1);
        end
    endtask

    task automatic test_two_block_r4();
        int lat; hash_t dig; logic [7:0] t;
        hash_t exp1;
        exp1 = compress(iv_h, two_b1);
        run_block(2'd0, '0, two_b1, 8'h21, 4, lat, dig, t);
        mid_digest = dig;
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL two_b1_latency: got %0d want 18", lat); end
        checks++;
        if (dig !== exp1) begin errors++; $display("FAIL two_b1_digest: got %h want %h", dig, exp1); end
        run_block(2'd2, '0, two_b2, 8'h22, 4, lat, dig, t);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL two_b2_latency: got %0d want 18", lat); end
        checks++;
        if (dig !== two_h) begin errors++; $display("FAIL two_digest: got %h want %h", dig, two_h); end
        checks++;
        if (t !== 8'h22) begin errors++; $display("FAIL two_tag: got %h want 22", t); end
    endtask

    task automatic test_midstate();
        int lat; hash_t dig; logic [7:0] t;
        wait_idle();
        apply_reset();
        run_block(2'd1, mid_digest, two_b2, 8'h33, 4, lat, dig, t);
        checks++;
        if (dig !== two_h) begin errors++; $display("FAIL midstate_digest: got %h want %h", dig, two_h); end
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL midstate_latency: got %0d want 18", lat); end
    endtask

    task automatic test_backpressure();
        int lat; hash_t dig; logic [7:0] t;
        wait_idle();
        out_ready = 1'b0;
        run_block(2'd0, '0, abc_b, 8'hc3, 4, lat, dig, t);
        checks++;
        if (dig !== abc_h || lat !== 18) begin
            errors++; $display("FAIL bp_first: got %h lat %0d want %h lat 18", dig, lat, abc_h);
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            block    = {16{$urandom()}};
            @(posedge clk); #1;
            checks++;
            if (digest4 !== abc_h || out_tag4 !== 8'hc3) begin
                errors++; $display("FAIL bp_hold_data cycle %0d: got %h tag %h want %h tag c3",
                                   k, digest4, out_tag4, abc_h);
            end
            checks++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
                errors++; $display("FAIL bp_hold_ctrl cycle %0d: out_valid=%b in_ready=%b want 1 0",
                                   k, out_valid4, in_ready4);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                               out_valid4, in_ready4, busy4);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++; $display("FAIL bp_no_phantom: in_ready=%b want 1", in_ready4);
        end
    endtask

    task automatic test_reset_mid();
        int lat; int spurious; hash_t dig; logic [7:0] t;
        wait_idle();
        hash_sel = 2'd0; block = two_b1; in_tag = 8'h44; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL midreset_async: busy=%b out_valid=%b in_ready=%b want 0 0 1",
                               busy1, out_valid1, in_ready1);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid2 || out_valid4) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++; $display("FAIL midreset_spurious: got %0d out_valid cycles want 0", spurious);
        end
        run_block(2'd2, '0, abc_b, 8'h11, 1, lat, dig, t);
        checks++;
        if (dig !== abc_h) begin errors++; $display("FAIL midreset_chain_iv: got %h want %h", dig, abc_h); end
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL midreset_latency: got %0d want 66", lat); end
    endtask

    task automatic test_random_r2();
        int lat; hash_t dig; logic [7:0] t;
        hash_t chain, start, ih, exp;
        blk_t b;
        logic [1:0] sel;
        wait_idle();
        apply_reset();
        chain = iv_h;
        for (int i = 0; i < 50; i++) begin
            for (int j = 0; j < 16; j++) b[j] = $urandom();
            for (int j = 0; j < 8; j++) ih[j] = $urandom();
            sel = 2'($urandom_range(0, 3));
            start = (sel == 2'd1) ? ih : (sel == 2'd2) ? chain : iv_h;
            exp = compress(start, b);
            run_block(sel, ih, b, 8'(i), 2, lat, dig, t);
            checks++;
            if (dig !== exp) begin
                errors++; $display("FAIL rand_digest %0d sel %0d: got %h want %h", i, sel, dig, exp);
            end
            checks++;
            if (lat !== 34 || t !== 8'(i)) begin
                errors++; $display("FAIL rand_timing %0d: lat %0d tag %h want 34 %h", i, lat, t, 8'(i));
            end
            chain = exp;
        end
    endtask

    initial begin
        iv_h  = mk8(32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19);
        abc_h = mk8(32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad);
        two_h = mk8(32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1);
        abc_b = '0;
        abc_b[0]  = 32'h61626380;
        abc_b[15] = 32'h00000018;
        two_b1 = '0;
        two_b1[0]  = 32'h61626364; two_b1[1]  = 32'h62636465; two_b1[2]  = 32'h63646566;
        two_b1[3]  = 32'h64656667; two_b1[4]  = 32'h65666768; two_b1[5]  = 32'h66676869;
        two_b1[6]  = 32'h6768696a; two_b1[7]  = 32'h68696a6b; two_b1[8]  = 32'h696a6b6c;
        two_b1[9]  = 32'h6a6b6c6d; two_b1[10] = 32'h6b6c6d6e; two_b1[11] = 32'h6c6d6e6f;
        two_b1[12] = 32'h6d6e6f70; two_b1[13] = 32'h6e6f7071; two_b1[14] = 32'h80000000;
        two_b2 = '0;
        two_b2[15] = 32'h000001c0;
        mid_digest = '0;

        #2;
        test_reset();
        test_abc_r1();
        test_two_block_r4();
        test_midstate();
        test_backpressure();
        test_reset_mid();
        test_random_r2();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_block_engine.md
# sha256_block_engine

Parametrised successor to the single-block SHA-256 compression FSM. Compresses one 512-bit message block per transaction with valid/ready handshakes on both sides and a configurable number of rounds per clock (1, 2 or 4). Chains blocks across transactions via an internal chaining register, so multi-block messages and midstate-resumed hashing (e.g. the bitcoin nonce loop) need no external feedback. Sits between the message/padding front end and the digest consumer.

## Interface
- ROUNDS_PER_CYCLE, 1, rounds per ROUND cycle; legal values 1, 2, 4; anything else is a elaboration error.
- TAG_W, 8, width of the opaque transaction tag carried from input to output.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  block, hash_sel, init_hash and in_tag are valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- block  in  32x16  message words W0..W15, big-endian word order, already padded.
- hash_sel  in  2  starting hash: 0 = FIPS IV, 1 = init_hash, 2 = internal chaining register; 3 reserved, treated as 0.
- init_hash  in  32x8  explicit starting hash H0..H7.
- in_tag  in  TAG_W  tag captured on accept.
- out_valid  out  1  digest and out_tag are valid.
- out_ready  in  1  consumer accepts digest.
- digest  out  32x8  H0..H7 after this block.
- out_tag  out  TAG_W  tag of the completed transaction.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, PREP, ROUND, FINAL, OUT.
- IDLE: in_ready=1. On in_valid: capture block, in_tag, and the selected starting hash into the base registers H0..H7; go to PREP.
- PREP: copy base into working a..h; load the 16-word schedule window; clear the round counter; go to ROUND.
- ROUND: apply ROUNDS_PER_CYCLE chained rounds per cycle using K[t] and W[t]. The schedule window advances by ROUNDS_PER_CYCLE words per cycle, with each new word given by σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16]. The counter increments by ROUNDS_PER_CYCLE. After round 63, go to FINAL.
- FINAL: digest[i] <= base[i] + working[i] (mod 2^32); chaining register <= same value; out_tag <= captured tag; out_valid <= 1; go to OUT.
- OUT: hold digest, out_tag and out_valid stable until out_valid && out_ready at an edge. Then out_valid <= 0 and go to IDLE.
- Outputs do not accept in the same cycle that the digest is consumed.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge and may change afterwards.
- All additions wrap mod 2^32. Rotates are true 32-bit rotates.

## Timing
- Reset values: state IDLE, in_ready 1 (combinational from state), out_valid 0, busy 0, digest all-zero, out_tag 0, chaining register = FIPS IV (6a09e667 … 5be0cd19), round counter 0.
- Latency: the accept edge is edge 0. out_valid is high after edge 2+64/ROUNDS_PER_CYCLE: 66 for R=1, 34 for R=2, 18 for R=4.
- Minimum block-to-block interval is 64/R+4 cycles when out_ready is held high.
- Reset asserted mid-transaction: the in-flight block is discarded, no out_valid is produced, and the chaining register returns to IV.
- Using hash_sel=2 right after reset gives IV.

## Structure
- Package sha256_pkg: K[0:63] constant array, IV[0:7] constant, rotr, Σ0/Σ1/σ0/σ1/ch/maj functions, state enum typedef, and a word8_t typedef for a 32x8 hash.
- Sub-module sha256_round is purely combinational: it maps (a..h, K+W) to the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain by a generate loop.

## Test plan
- "abc" single padded block, hash_sel=0, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid exactly 66 edges after accept, tag echoed.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks (hash_sel 0 then 2), R=4 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, each block 18 edges.
- Same message: capture the block-1 digest, reset, then send block 2 with hash_sel=1 and init_hash = captured digest -> same final digest.
- Backpressure: out_ready low for 10 cycles -> digest and out_tag stable, in_ready 0, in_valid pulses ignored; on release, a one-cycle handshake, then in_ready 1.
- reset_n pulsed at round 30, then "abc" with hash_sel=2 -> IV-based "abc" digest, with no spurious out_valid.
- R=2 regression over 50 random single blocks vs. a reference model -> all digests match, 34-edge latency each.
